// File: rtl/simd_pkg.sv
// rtl/simd_pkg.sv - shared constants, opcodes and FSM states for the SIMD sequencer
package simd_pkg;

  localparam int LANES = 3;
  localparam int AW    = 4;

  typedef enum logic [1:0] {
    OP_NOP  = 2'b00,
    OP_LOAD = 2'b01,
    OP_READ = 2'b10,
    OP_RSVD = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_TAIL,
    ST_READ,
    ST_RWAIT,
    ST_FIN
  } state_e;

endpackage

// File: rtl/simd_seq_ctrl_if.sv
// rtl/simd_seq_ctrl_if.sv - command handshake and PE memory control bundle
interface simd_seq_ctrl_if;
  import simd_pkg::*;

  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [LANES-1:0] cmd_mask;
  logic [AW-1:0]    cmd_base;
  logic [AW-1:0]    cmd_len;
  logic [AW-1:0]    cmd_rb;
  logic             data_req;
  logic [LANES-1:0] en_write;
  logic [AW-1:0]    wr_addr;
  logic             en_read;
  logic [AW-1:0]    rd_addr_a;
  logic [AW-1:0]    rd_addr_b;
  logic             rd_valid;
  logic             done;
  logic             err;

  // issue side: drives commands, observes the PE control lines
  modport master (
    output cmd_valid, cmd_op, cmd_mask, cmd_base, cmd_len, cmd_rb,
    input  cmd_ready, data_req, en_write, wr_addr, en_read,
    input  rd_addr_a, rd_addr_b, rd_valid, done, err
  );

  // sequencer side
  modport slave (
    input  cmd_valid, cmd_op, cmd_mask, cmd_base, cmd_len, cmd_rb,
    output cmd_ready, data_req, en_write, wr_addr, en_read,
    output rd_addr_a, rd_addr_b, rd_valid, done, err
  );

endinterface

// File: rtl/simd_addr_ctr.sv
// rtl/simd_addr_ctr.sv - loadable wrap-around beat counter with last-beat flag
module simd_addr_ctr
  import simd_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic          inc,
  input  logic [AW-1:0] load_val,
  input  logic [AW-1:0] len,
  output logic [AW-1:0] count,
  output logic          last
);

  logic [AW-1:0] count_q;
  logic [AW-1:0] count_d;

  // load wins over increment; increment wraps naturally at AW bits
  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (inc) begin
      count_d = count_q + 1'b1;
    end
  end

  // counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;
  assign last  = (count_q == len);

endmodule

// File: rtl/simd_seq_ctrl.sv
// rtl/simd_seq_ctrl.sv - command sequencer driving the three-lane PE memory array
module simd_seq_ctrl
  import simd_pkg::*;
(
  input  logic           clk,
  input  logic           rst_n,
  simd_seq_ctrl_if.slave bus
);

  state_e           state_q, state_d;
  logic [LANES-1:0] mask_q, mask_d;
  logic [AW-1:0]    base_q, base_d;
  logic [AW-1:0]    len_q, len_d;
  logic             data_req_q, data_req_d;
  logic [LANES-1:0] en_write_q, en_write_d;
  logic [AW-1:0]    wr_addr_q, wr_addr_d;
  logic             en_read_q, en_read_d;
  logic [AW-1:0]    rd_addr_a_q, rd_addr_a_d;
  logic [AW-1:0]    rd_addr_b_q, rd_addr_b_d;
  logic             rd_valid_q, rd_valid_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  logic             accept;
  logic [AW-1:0]    beat;
  logic             beat_last;

  assign accept = bus.cmd_valid && (state_q == ST_IDLE);

  // beat index of the LOAD cycle in progress; restarted on every accept
  simd_addr_ctr u_ctr (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (accept),
    .inc      (state_q == ST_LOAD),
    .load_val ('0),
    .len      (len_q),
    .count    (beat),
    .last     (beat_last)
  );

  // next-state and next-output logic; every output is registered so the
  // value computed here appears in the cycle after the edge.
  // The opcode needs no latch of its own: the state it selects carries it,
  // and READ addresses are captured straight into their output registers.
  always_comb begin
    state_d     = state_q;
    mask_d      = mask_q;
    base_d      = base_q;
    len_d       = len_q;
    data_req_d  = 1'b0;
    en_write_d  = '0;
    wr_addr_d   = wr_addr_q;
    en_read_d   = 1'b0;
    rd_addr_a_d = rd_addr_a_q;
    rd_addr_b_d = rd_addr_b_q;
    rd_valid_d  = 1'b0;
    done_d      = 1'b0;
    err_d       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.cmd_valid) begin
          mask_d = bus.cmd_mask;
          base_d = bus.cmd_base;
          len_d  = bus.cmd_len;
          case (bus.cmd_op)
            OP_LOAD: begin
              state_d    = ST_LOAD;
              data_req_d = 1'b1;
            end
            OP_READ: begin
              state_d     = ST_READ;
              en_read_d   = 1'b1;
              rd_addr_a_d = bus.cmd_base;
              rd_addr_b_d = bus.cmd_rb;
            end
            default: begin
              state_d = ST_FIN;
              done_d  = 1'b1;
              err_d   = (bus.cmd_op == OP_RSVD);
            end
          endcase
        end
      end
      ST_LOAD: begin
        // beat presented now lands in the staging regs; write it next cycle
        en_write_d = mask_q;
        wr_addr_d  = base_q + beat;
        if (beat_last) begin
          state_d = ST_TAIL;
          done_d  = 1'b1;
        end else begin
          data_req_d = 1'b1;
        end
      end
      ST_READ: begin
        state_d    = ST_RWAIT;
        rd_valid_d = 1'b1;
        done_d     = 1'b1;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // FSM state, latched command fields and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      mask_q      <= '0;
      base_q      <= '0;
      len_q       <= '0;
      data_req_q  <= 1'b0;
      en_write_q  <= '0;
      wr_addr_q   <= '0;
      en_read_q   <= 1'b0;
      rd_addr_a_q <= '0;
      rd_addr_b_q <= '0;
      rd_valid_q  <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      mask_q      <= mask_d;
      base_q      <= base_d;
      len_q       <= len_d;
      data_req_q  <= data_req_d;
      en_write_q  <= en_write_d;
      wr_addr_q   <= wr_addr_d;
      en_read_q   <= en_read_d;
      rd_addr_a_q <= rd_addr_a_d;
      rd_addr_b_q <= rd_addr_b_d;
      rd_valid_q  <= rd_valid_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign bus.cmd_ready = (state_q == ST_IDLE);
  assign bus.data_req  = data_req_q;
  assign bus.en_write  = en_write_q;
  assign bus.wr_addr   = wr_addr_q;
  assign bus.en_read   = en_read_q;
  assign bus.rd_addr_a = rd_addr_a_q;
  assign bus.rd_addr_b = rd_addr_b_q;
  assign bus.rd_valid  = rd_valid_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;

endmodule

// File: tb/tb_simd_seq_ctrl.sv
// tb/tb_simd_seq_ctrl.sv - directed self-checking bench for simd_seq_ctrl
module tb_simd_seq_ctrl;

  logic clk;
  logic rst_n;
  int   vectors;
  int   miscompares;

  simd_seq_ctrl_if bus();

  simd_seq_ctrl u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // lane data sources, staging registers and PE memories around the sequencer
  logic [11:0] lane_data [3];
  logic [11:0] stage     [3];
  logic [11:0] mem       [3][16];
  logic [11:0] rda       [3];
  logic [11:0] rdb       [3];
  logic [11:0] exp_mem   [3][16];

  // PE memory model: staging capture, masked write, registered dual read
  always_ff @(posedge clk) begin
    for (int l = 0; l < 3; l++) begin
      if (bus.data_req) stage[l] <= lane_data[l];
      if (bus.en_write[l]) mem[l][bus.wr_addr] <= stage[l];
      if (bus.en_read) begin
        rda[l] <= mem[l][bus.rd_addr_a];
        rdb[l] <= mem[l][bus.rd_addr_b];
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle_outputs(input string tag);
    chk({tag, " cmd_ready"}, 32'(bus.cmd_ready), 32'd1);
    chk({tag, " data_req"},  32'(bus.data_req),  32'd0);
    chk({tag, " en_write"},  32'(bus.en_write),  32'd0);
    chk({tag, " en_read"},   32'(bus.en_read),   32'd0);
    chk({tag, " rd_valid"},  32'(bus.rd_valid),  32'd0);
    chk({tag, " done"},      32'(bus.done),      32'd0);
    chk({tag, " err"},       32'(bus.err),       32'd0);
  endtask

  function automatic logic [11:0] beat_data(input logic [3:0] tag, input int l, input int c);
    return {tag, 4'(l), 4'(c)};
  endfunction

  // present a LOAD in an idle cycle and check every cycle of its occupancy;
  // with disturb set, cmd_* is scrambled and held valid while busy
  task automatic run_load(input logic [2:0] m, input logic [3:0] b, input logic [3:0] n,
                          input logic [3:0] tag, input bit disturb);
    int nn;
    logic [3:0] a;
    nn = int'(n);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = 2'b01;
    bus.cmd_mask  = m;
    bus.cmd_base  = b;
    bus.cmd_len   = n;
    bus.cmd_rb    = 4'd0;
    tick();
    bus.cmd_valid = disturb;
    if (disturb) begin
      bus.cmd_op   = 2'b10;
      bus.cmd_mask = ~m;
      bus.cmd_base = b + 4'd7;
      bus.cmd_len  = 4'd0;
    end
    for (int c = 0; c <= nn + 1; c++) begin
      for (int l = 0; l < 3; l++) lane_data[l] = beat_data(tag, l, c);
      chk($sformatf("load c%0d data_req", c), 32'(bus.data_req), 32'(c <= nn));
      chk($sformatf("load c%0d en_write", c), 32'(bus.en_write), (c >= 1) ? 32'(m) : 32'd0);
      chk($sformatf("load c%0d done", c), 32'(bus.done), 32'(c == nn + 1));
      chk($sformatf("load c%0d cmd_ready", c), 32'(bus.cmd_ready), 32'd0);
      if (c >= 1) begin
        a = b + 4'(c - 1);
        chk($sformatf("load c%0d wr_addr", c), 32'(bus.wr_addr), 32'(a));
        for (int l = 0; l < 3; l++)
          if (m[l]) exp_mem[l][a] = beat_data(tag, l, c - 1);
      end
      if (c == nn + 1) bus.cmd_valid = 1'b0;
      tick();
    end
    idle_outputs("load end");
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    for (int l = 0; l < 3; l++) lane_data[l] = 12'h000;

    // reset held with a LOAD already on the bus: nothing may be accepted
    rst_n         = 1'b0;
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = 2'b01;
    bus.cmd_mask  = 3'b101;
    bus.cmd_base  = 4'd2;
    bus.cmd_len   = 4'd2;
    bus.cmd_rb    = 4'd0;
    tick();
    tick();
    idle_outputs("reset");
    chk("reset wr_addr", 32'(bus.wr_addr), 32'd0);
    chk("reset rd_addr_a", 32'(bus.rd_addr_a), 32'd0);
    tick();
    idle_outputs("reset held");
    @(negedge clk);
    rst_n = 1'b1;

    // first edge after release accepts LOAD mask=101 base=2 len=2
    run_load(3'b101, 4'd2, 4'd2, 4'h1, 1'b0);

    // wrap-around burst: 14, 15, 0, 1
    run_load(3'b111, 4'd14, 4'd3, 4'h2, 1'b0);

    // burst covering 5..9 with cmd_* disturbed and held valid while busy
    run_load(3'b111, 4'd5, 4'd4, 4'h3, 1'b1);

    // READ pair base=5, rb=9
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = 2'b10;
    bus.cmd_base  = 4'd5;
    bus.cmd_rb    = 4'd9;
    tick();
    bus.cmd_valid = 1'b0;
    chk("read c0 en_read", 32'(bus.en_read), 32'd1);
    chk("read c0 rd_addr_a", 32'(bus.rd_addr_a), 32'd5);
    chk("read c0 rd_addr_b", 32'(bus.rd_addr_b), 32'd9);
    chk("read c0 rd_valid", 32'(bus.rd_valid), 32'd0);
    chk("read c0 done", 32'(bus.done), 32'd0);
    chk("read c0 cmd_ready", 32'(bus.cmd_ready), 32'd0);
    tick();
    chk("read c1 en_read", 32'(bus.en_read), 32'd0);
    chk("read c1 rd_valid", 32'(bus.rd_valid), 32'd1);
    chk("read c1 done", 32'(bus.done), 32'd1);
    chk("read c1 cmd_ready", 32'(bus.cmd_ready), 32'd0);
    for (int l = 0; l < 3; l++) begin
      chk($sformatf("read lane%0d port a", l), 32'(rda[l]), 32'(exp_mem[l][5]));
      chk($sformatf("read lane%0d port b", l), 32'(rdb[l]), 32'(exp_mem[l][9]));
    end
    tick();
    idle_outputs("read end");
    chk("read hold rd_addr_a", 32'(bus.rd_addr_a), 32'd5);
    chk("read hold rd_addr_b", 32'(bus.rd_addr_b), 32'd9);

    // reserved opcode then NOP with cmd_valid held high throughout
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = 2'b11;
    tick();
    chk("rsvd c0 err", 32'(bus.err), 32'd1);
    chk("rsvd c0 done", 32'(bus.done), 32'd1);
    chk("rsvd c0 cmd_ready", 32'(bus.cmd_ready), 32'd0);
    bus.cmd_op = 2'b00;
    tick();
    idle_outputs("rsvd c1");
    tick();
    chk("nop c0 done", 32'(bus.done), 32'd1);
    chk("nop c0 err", 32'(bus.err), 32'd0);
    chk("nop c0 cmd_ready", 32'(bus.cmd_ready), 32'd0);
    bus.cmd_valid = 1'b0;
    tick();
    idle_outputs("nop end");

    // reset during a len=5 burst at base 14, after only beat 0 was written
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = 2'b01;
    bus.cmd_mask  = 3'b111;
    bus.cmd_base  = 4'd14;
    bus.cmd_len   = 4'd5;
    tick();
    bus.cmd_valid = 1'b0;
    for (int l = 0; l < 3; l++) lane_data[l] = beat_data(4'h4, l, 0);
    tick();
    for (int l = 0; l < 3; l++) lane_data[l] = beat_data(4'h4, l, 1);
    chk("abort c1 en_write", 32'(bus.en_write), 32'h7);
    chk("abort c1 wr_addr", 32'(bus.wr_addr), 32'd14);
    for (int l = 0; l < 3; l++) exp_mem[l][14] = beat_data(4'h4, l, 0);
    tick();
    for (int l = 0; l < 3; l++) lane_data[l] = beat_data(4'h4, l, 2);
    rst_n = 1'b0;
    #1;
    idle_outputs("abort");
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("abort hold%0d done", k), 32'(bus.done), 32'd0);
      chk($sformatf("abort hold%0d en_write", k), 32'(bus.en_write), 32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    idle_outputs("abort release");
    for (int l = 0; l < 3; l++) begin
      chk($sformatf("abort lane%0d addr14", l), 32'(mem[l][14]), 32'(exp_mem[l][14]));
      chk($sformatf("abort lane%0d addr15", l), 32'(mem[l][15]), 32'(exp_mem[l][15]));
      chk($sformatf("wrap lane%0d addr1", l), 32'(mem[l][1]), 32'(exp_mem[l][1]));
      chk($sformatf("mask lane%0d addr3", l), 32'(mem[l][3]), (l == 1) ? 32'(mem[1][3]) : 32'(exp_mem[l][3]));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/simd_seq_ctrl.md
# simd_seq_ctrl

Instruction sequencer for the three-lane SIMD processing-element memory array. It accepts one command at a time over a valid/ready handshake and expands it into cycle-accurate control for the lane datapath:
- per-lane write enables and a broadcast write address;
- read enable and the two read addresses;
- a data-request strobe that aligns upstream lane data with the one-cycle input staging register in front of each PE memory.

It sits between the instruction issue logic and the PE memory array, and replaces the hand-driven en_write/en_read/address inputs.

## Interface
- LANES, 3, number of PE lanes
- AW, 4, PE memory address width (depth 2^AW)
- clk  input  1  rising-edge clock for all state
- rst_n  input  1  asynchronous, active-low reset
- cmd_valid  input  1  command present
- cmd_ready  output  1  sequencer can accept a command
- cmd_op  input  2  00 NOP, 01 LOAD burst, 10 READ pair, 11 reserved
- cmd_mask  input  LANES  lanes enabled for LOAD writes
- cmd_base  input  AW  LOAD start address / READ port-A address
- cmd_len  input  AW  LOAD beat count minus one (1..2^AW beats)
- cmd_rb  input  AW  READ port-B address
- data_req  output  1  upstream must drive all lane data buses this cycle
- en_write  output  LANES  per-lane PE memory write enable
- wr_addr  output  AW  write address, broadcast to all lanes
- en_read  output  1  PE memory read enable, all lanes
- rd_addr_a  output  AW  read port-A address, all lanes
- rd_addr_b  output  AW  read port-B address, all lanes
- rd_valid  output  1  PE read data valid on all lane outputs
- done  output  1  one-cycle pulse when a command completes
- err  output  1  one-cycle pulse when a reserved opcode is accepted

## Operation
- FSM states: IDLE, LOAD, TAIL, READ, RWAIT, FIN.
- cmd_ready = (state == IDLE). A command is accepted at a rising edge where cmd_valid && cmd_ready.
- Accepted fields are latched: op, mask, base, len, rb. Later changes on cmd_* have no effect until the FSM returns to IDLE.
- **NOP:** IDLE -> FIN. FIN drives done=1 for one cycle, then -> IDLE.
- **Reserved opcode (11):** same path as NOP, with err=1 in the cycle after acceptance.
- **LOAD:** IDLE -> LOAD.
  - Beat counter starts at 0. data_req=1 for every LOAD cycle.
  - Beat i is presented in LOAD cycle i. The lane staging registers capture it at the end of that cycle.
  - The following cycle drives en_write = latched mask and wr_addr = base + i (mod 2^AW).
  - After beat len -> TAIL. TAIL drives the final write with data_req=0 and done=1, then -> IDLE.
- **mask = 0:** the LOAD sequence and timing are unchanged; en_write stays all-zero.
- **READ:** IDLE -> READ. READ drives en_read=1, rd_addr_a=base, rd_addr_b=rb for one cycle, then -> RWAIT.
  - RWAIT drives rd_valid=1 and done=1. PE memories present registered read data one cycle after en_read. Then -> IDLE.
- Address arithmetic is AW bits, unsigned, and wraps from 2^AW-1 to 0. Example: base=14, len=3 writes 14, 15, 0, 1.
- data_req, en_write, en_read, rd_valid, done and err are registered. They are zero in every state or cycle not listed above.
- wr_addr, rd_addr_a and rd_addr_b hold their last driven value while idle.

## Timing
- Reset (async assert, sync deassert to clk): state=IDLE; all outputs 0 except cmd_ready=1; beat counter and latched fields 0.
- Reset mid-command: any in-flight write or read is abandoned, with no done pulse.
- Command accepted at edge E0; cycle n is the cycle after edge E0+n.
- **LOAD occupancy:** len+2 cycles.
  - data_req in cycles 0..len.
  - en_write in cycles 1..len+1.
  - done in cycle len+1.
  - cmd_ready returns in cycle len+2.
- **READ occupancy:** 2 cycles. en_read in cycle 0; rd_valid and done in cycle 1; cmd_ready in cycle 2.
- **NOP/reserved occupancy:** 1 cycle. done (and err) in cycle 0.
- Commands are not overlapped: cmd_ready stays low in the done cycle. Maximum command rate is one per occupancy + 1 cycles.
- cmd_valid is not required to stay high after acceptance. cmd_valid while busy is ignored and not queued.

## Structure
- Package simd_pkg: op encodings (OP_NOP, OP_LOAD, OP_READ, OP_RSVD), FSM state enum, default LANES/AW constants.
- Sub-module simd_addr_ctr: loadable AW-bit wrap-around beat/address counter with last-beat flag (count == len). It is instantiated once and drives wr_addr generation.
- The FSM and output registers live in the top level.

## Test plan
- Reset held low with cmd_valid=1 -> all outputs 0, cmd_ready=1, nothing accepted; release -> first command accepted on the next edge.
- LOAD mask=3'b101, base=2, len=2 -> data_req cycles 0-2; en_write=101 in cycles 1-3 with wr_addr 2, 3, 4; done in cycle 3; cmd_ready in cycle 4.
- LOAD base=14, len=3, mask=111 -> wr_addr sequence 14, 15, 0, 1; exactly 4 en_write cycles.
- READ base=5, rb=9 -> cycle 0: en_read=1, rd_addr_a=5, rd_addr_b=9; cycle 1: rd_valid=1, done=1; readback matches data written earlier.
- cmd_valid held high with op=11 and then op=00 -> err+done in cycle 0 only; next command accepted at E2; cmd_* changes during LOAD have no effect.
- rst_n asserted during LOAD beat 1 of len=5 -> outputs 0 immediately; no done pulse; only beat 0 was written.
